// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use, redirect, multi-cycle EX, fence drain, LSU back-pressure.
// Optional stall/flush performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int MULTI_LAT = 4,
  parameter int CNT_W     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1_addr,
  input  logic        id_rs1_used,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_rs2_used,
  input  logic        ex_valid,
  input  logic [4:0]  ex_w_addr,
  input  logic        ex_w_ena,
  input  logic        ex_mem_ena,
  input  logic        ex_mem_wr,
  input  logic        ex_multi,
  input  logic        ex_redirect,
  input  logic        ex_fence,
  input  logic        mem_valid,
  input  logic        wb_valid,
  input  logic        mem_busy,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        id_flush,
  output logic        ex_bubble,
  output logic        pc_redirect,
  output logic        fence_done,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
);

  // state | meaning
  // RUN   | normal issue, hazards resolved combinationally
  // MULTI | multi-cycle EX op in flight, cnt counts remaining stall cycles
  // DRAIN | fence waiting for MEM/WB to empty and LSU to go idle
  typedef enum logic [1:0] {RUN, MULTI, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             stall_c, flush_c, bubble_c, redirect_c, done_c, id_stall_c;

  always_comb begin
    lu = ex_valid & ex_mem_ena & ~ex_mem_wr & ex_w_ena & (ex_w_addr != 5'd0) & id_valid &
         ((id_rs1_used & (id_rs1_addr == ex_w_addr)) |
          (id_rs2_used & (id_rs2_addr == ex_w_addr)));
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    id_stall_c = 1'b0;
    flush_c    = 1'b0;
    bubble_c   = 1'b0;
    redirect_c = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          stall_c    = 1'b1;
          id_stall_c = 1'b1;
        end else if (ex_valid & ex_redirect) begin
          redirect_c = 1'b1;
          flush_c    = 1'b1;
          bubble_c   = 1'b1;
        end else if (ex_valid & ex_multi) begin
          stall_c    = 1'b1;
          id_stall_c = 1'b1;
          state_d    = MULTI;
          cnt_d      = CNT_W'(MULTI_LAT - 2);
        end else if (ex_valid & ex_fence) begin
          stall_c    = 1'b1;
          id_stall_c = 1'b1;
          state_d    = DRAIN;
        end else if (lu) begin
          // only IF is held; ID/EX takes the bubble so the load moves on
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      MULTI: begin
        if (cnt_q != '0) begin
          stall_c    = 1'b1;
          id_stall_c = 1'b1;
          cnt_d      = cnt_q - CNT_W'(1);
        end else if (mem_busy) begin
          stall_c    = 1'b1;
          id_stall_c = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (mem_valid | wb_valid | mem_busy) begin
          stall_c    = 1'b1;
          id_stall_c = 1'b1;
        end else begin
          done_c  = 1'b1;
          flush_c = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // outputs are combinational, so gate them with reset to force 0 during reset
  assign if_stall    = stall_c & reset;
  assign ex_stall    = stall_c & id_stall_c & reset;
  assign id_stall    = id_stall_c & reset;
  assign id_flush    = flush_c & reset;
  assign ex_bubble   = bubble_c & reset;
  assign pc_redirect = redirect_c & reset;
  assign fence_done  = done_c & reset;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, if_stall};
    perf_flush_d = perf_flush_q + {31'd0, id_flush};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_pipe_ctrl;
  localparam int MULTI_LAT = 4;
  localparam int CNT_W     = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic id_valid, id_rs1_used, id_rs2_used;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_w_addr;
  logic ex_valid, ex_w_ena, ex_mem_ena, ex_mem_wr, ex_multi, ex_redirect, ex_fence;
  logic mem_valid, wb_valid, mem_busy;
  logic if_stall, id_stall, ex_stall, id_flush, ex_bubble, pc_redirect, fence_done;
  logic [31:0] perf_stall, perf_flush;
  logic [6:0] outs;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  pipe_ctrl #(.MULTI_LAT(MULTI_LAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_w_addr(ex_w_addr), .ex_w_ena(ex_w_ena),
    .ex_mem_ena(ex_mem_ena), .ex_mem_wr(ex_mem_wr), .ex_multi(ex_multi),
    .ex_redirect(ex_redirect), .ex_fence(ex_fence),
    .mem_valid(mem_valid), .wb_valid(wb_valid), .mem_busy(mem_busy),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .id_flush(id_flush), .ex_bubble(ex_bubble), .pc_redirect(pc_redirect),
    .fence_done(fence_done), .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  // {if_stall, id_stall, ex_stall, id_flush, ex_bubble, pc_redirect, fence_done}
  assign outs = {if_stall, id_stall, ex_stall, id_flush, ex_bubble, pc_redirect, fence_done};

  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_STALL  = 7'b1110000;
  localparam logic [6:0] O_LU     = 7'b1000100;
  localparam logic [6:0] O_REDIR  = 7'b0001110;
  localparam logic [6:0] O_FDONE  = 7'b0001001;

  task automatic idle();
    id_valid = 0; id_rs1_addr = 0; id_rs1_used = 0; id_rs2_addr = 0; id_rs2_used = 0;
    ex_valid = 0; ex_w_addr = 0; ex_w_ena = 0; ex_mem_ena = 0; ex_mem_wr = 0;
    ex_multi = 0; ex_redirect = 0; ex_fence = 0;
    mem_valid = 0; wb_valid = 0; mem_busy = 0;
  endtask

  task automatic set_lu(input logic [4:0] wa);
    ex_valid = 1; ex_mem_ena = 1; ex_mem_wr = 0; ex_w_ena = 1; ex_w_addr = wa;
    id_valid = 1; id_rs1_used = 1; id_rs1_addr = 5'd5; id_rs2_used = 0; id_rs2_addr = 5'd0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle();
    mem_busy = 1; ex_valid = 1; ex_redirect = 1; set_lu(5'd5);
    @(negedge clock);
    n_total++;
    if (outs !== O_NONE) $display("FAIL reset_outs: got %b expected %b", outs, O_NONE);
    else n_pass++;
    n_total++;
    if (perf_stall !== 32'd0 || perf_flush !== 32'd0)
      $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_stall, perf_flush);
    else n_pass++;
    idle();
    reset = 1;
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [6:0] exp_v [0:4];
    exp_v[0] = O_LU; exp_v[1] = O_NONE; exp_v[2] = O_NONE; exp_v[3] = O_LU; exp_v[4] = O_NONE;
    for (int c = 0; c < 5; c++) begin
      idle();
      case (c)
        0: set_lu(5'd5);
        1: begin set_lu(5'd5); ex_valid = 0; end
        2: set_lu(5'd0);
        3: begin set_lu(5'd9); id_rs1_addr = 5'd1; id_rs2_used = 1; id_rs2_addr = 5'd9; end
        default: begin set_lu(5'd5); ex_mem_wr = 1; end
      endcase
      @(negedge clock);
      n_total++;
      if (outs !== exp_v[c]) $display("FAIL load_use_c%0d: got %b expected %b", c, outs, exp_v[c]);
      else n_pass++;
`ifdef PIPE_CTRL_PERF_EN
      if (c == 1) begin
        n_total++;
        if (perf_stall !== 32'd1 || perf_flush !== 32'd0)
          $display("FAIL perf_after_lu: got %0d/%0d expected 1/0", perf_stall, perf_flush);
        else n_pass++;
      end
`endif
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    idle(); set_lu(5'd5); ex_redirect = 1; ex_multi = 1; ex_fence = 1;
    @(negedge clock);
    n_total++;
    if (outs !== O_REDIR) $display("FAIL redirect_over_lu: got %b expected %b", outs, O_REDIR);
    else n_pass++;
    next_cycle();
    idle(); set_lu(5'd5); ex_redirect = 1; mem_busy = 1;
    @(negedge clock);
    n_total++;
    if (outs !== O_STALL) $display("FAIL freeze_over_redirect: got %b expected %b", outs, O_STALL);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_multi(input bit busy);
    logic [6:0] e;
    int last;
    last = busy ? 7 : 4;
    for (int c = 0; c <= last; c++) begin
      idle();
      if (c < last) begin ex_valid = 1; ex_multi = 1; end
      else set_lu(5'd5);
      if (busy && c >= 2 && c <= 5) mem_busy = 1;
      if (c == last) e = O_LU;
      else if (c <= (busy ? 5 : 2)) e = O_STALL;
      else e = O_NONE;
      @(negedge clock);
      n_total++;
      if (outs !== e) $display("FAIL multi_busy%0d_c%0d: got %b expected %b", busy, c, outs, e);
      else n_pass++;
      next_cycle();
    end
    idle();
  endtask

  task automatic test_fence();
    logic [6:0] e;
    for (int c = 0; c <= 4; c++) begin
      idle();
      if (c <= 3) begin ex_valid = 1; ex_fence = 1; end
      mem_valid = (c < 2);
      wb_valid  = (c < 3);
      e = (c <= 2) ? O_STALL : (c == 3) ? O_FDONE : O_NONE;
      @(negedge clock);
      n_total++;
      if (outs !== e) $display("FAIL fence_c%0d: got %b expected %b", c, outs, e);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    idle(); ex_valid = 1; ex_multi = 1;
    next_cycle();
    next_cycle();
    mem_busy = 1;
    reset = 0;
    #1;
    n_total++;
    if (outs !== O_NONE) $display("FAIL async_reset_outs: got %b expected %b", outs, O_NONE);
    else n_pass++;
    @(negedge clock);
    idle();
    reset = 1;
    next_cycle();
    set_lu(5'd5);
    @(negedge clock);
    n_total++;
    if (outs !== O_LU) $display("FAIL after_reset_run: got %b expected %b", outs, O_LU);
    else n_pass++;
    next_cycle();
    idle();
  endtask

  task automatic test_random();
    int age;
    bit drain;
    bit lu;
    logic [6:0] e;
    int fails_cmp;
    int fails_ex;
    longint ps, pf;
    age = -1; drain = 0; ps = 0; pf = 0; fails_cmp = 0; fails_ex = 0;
    idle();
    reset = 0;
    #2;
    reset = 1;
    next_cycle();
    for (int i = 0; i < 500; i++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs1_used = $urandom_range(0, 1) == 1;
      id_rs2_addr = 5'($urandom_range(0, 3));
      id_rs2_used = $urandom_range(0, 1) == 1;
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_w_addr   = 5'($urandom_range(0, 3));
      ex_w_ena    = ($urandom_range(0, 3) != 0);
      ex_mem_ena  = $urandom_range(0, 1) == 1;
      ex_mem_wr   = ($urandom_range(0, 3) == 0);
      ex_multi    = ($urandom_range(0, 11) == 0);
      ex_redirect = ($urandom_range(0, 15) == 0);
      ex_fence    = ($urandom_range(0, 15) == 0);
      mem_valid   = $urandom_range(0, 1) == 1;
      wb_valid    = $urandom_range(0, 1) == 1;
      mem_busy    = ($urandom_range(0, 4) == 0);
      lu = ex_valid && ex_mem_ena && !ex_mem_wr && ex_w_ena && ex_w_addr != 0 && id_valid &&
           ((id_rs1_used && id_rs1_addr == ex_w_addr) || (id_rs2_used && id_rs2_addr == ex_w_addr));
      e = O_NONE;
      if (age >= 0) begin
        if (age < MULTI_LAT - 1 || mem_busy) e = O_STALL;
      end else if (drain) begin
        e = (mem_valid || wb_valid || mem_busy) ? O_STALL : O_FDONE;
      end else if (mem_busy) e = O_STALL;
      else if (ex_valid && ex_redirect) e = O_REDIR;
      else if (ex_valid && (ex_multi || ex_fence)) e = O_STALL;
      else if (lu) e = O_LU;
      @(negedge clock);
      n_total++;
      if (outs !== e) begin
        $display("FAIL random_c%0d: got %b expected %b", i, outs, e);
        fails_cmp++;
      end else n_pass++;
      n_total++;
      if (id_stall === 1'b1 && ex_bubble === 1'b1) begin
        $display("FAIL random_excl_c%0d: got id_stall=1 ex_bubble=1 expected not both", i);
        fails_ex++;
      end else n_pass++;
      if (fails_cmp + fails_ex > 10) break;
      if (age >= 0) age = e[6] ? age + 1 : -1;
      else if (drain) drain = e[6];
      else if (!mem_busy && ex_valid && !ex_redirect) begin
        if (ex_multi) age = 1;
        else if (ex_fence) drain = 1;
      end
      if (e[6]) ps++;
      if (e[3]) pf++;
      next_cycle();
    end
`ifdef PIPE_CTRL_PERF_EN
    n_total++;
    if (perf_stall !== 32'(ps) || perf_flush !== 32'(pf))
      $display("FAIL random_perf: got %0d/%0d expected %0d/%0d", perf_stall, perf_flush, ps, pf);
    else n_pass++;
`endif
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_redirect();
    test_multi(1'b0);
    test_multi(1'b1);
    test_fence();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX and EX/MEM stage registers. It resolves load-use hazards, branch redirects, multi-cycle EX operations (mul/div), fence/ecall drain, and LSU back-pressure. It is a small FSM with one down-counter; all control outputs are combinational from state plus inputs.

Parameters:
MULTI_LAT, 4, total EX occupancy in cycles of a multi-cycle op; legal range 2..16.
CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MULTI_LAT.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  IF/ID holds a valid instruction
id_rs1_addr  in  5  ID source register 1
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_addr  in  5  ID source register 2
id_rs2_used  in  1  ID instruction reads rs2
ex_valid  in  1  ID/EX holds a valid instruction
ex_w_addr  in  5  EX destination register
ex_w_ena  in  1  EX writes the regfile
ex_mem_ena  in  1  EX is a memory op
ex_mem_wr  in  1  1 = store, 0 = load
ex_multi  in  1  EX op is multi-cycle
ex_redirect  in  1  EX resolved a taken branch/jump
ex_fence  in  1  EX op requires pipeline drain
mem_valid  in  1  EX/MEM holds a valid instruction
wb_valid  in  1  MEM/WB holds a valid instruction
mem_busy  in  1  LSU waiting on the memory bus
if_stall  out  1  hold PC and IF/ID
id_stall  out  1  hold ID/EX
ex_stall  out  1  hold EX/MEM
id_flush  out  1  clear IF/ID valid at the next edge
ex_bubble  out  1  load a bubble into ID/EX at the next edge
pc_redirect  out  1  PC takes the EX branch target
fence_done  out  1  one-cycle pulse when the drain completes
perf_stall  out  32  stall-cycle count (optional feature)
perf_flush  out  32  flush-event count (optional feature)

Behaviour:
- States: RUN, MULTI, DRAIN. Counter cnt is CNT_W bits.
- Reset is asynchronous, active-low. While reset=0: state=RUN, cnt=0, every output 0, perf counters 0.
- Hazard term definitions:
  - freeze = mem_busy.
  - lu = ex_valid & ex_mem_ena & ~ex_mem_wr & ex_w_ena & (ex_w_addr!=0) & id_valid & ((id_rs1_used & rs1==ex_w_addr) | (id_rs2_used & rs2==ex_w_addr)).
- RUN, evaluated in strict priority order:
  1. freeze: if_stall=id_stall=ex_stall=1; all other outputs 0; state unchanged.
  2. ex_valid & ex_redirect: pc_redirect=1, id_flush=1, ex_bubble=1; no stall. Redirect overrides lu, ex_multi and ex_fence.
  3. ex_valid & ex_multi: if_stall=id_stall=ex_stall=1; next state MULTI with cnt=MULTI_LAT-2.
  4. ex_valid & ex_fence: if_stall=id_stall=ex_stall=1; next state DRAIN.
  5. lu: if_stall=1, ex_bubble=1, id_stall=0. Exactly one bubble per load-use pair.
  6. Otherwise all outputs 0.
- MULTI:
  - Stall all three stages while cnt!=0; cnt decrements by 1 per cycle.
  - At cnt==0 with ~mem_busy: release all stalls, go to RUN. EX leaves at this edge, so total EX occupancy = MULTI_LAT cycles.
  - At cnt==0 with mem_busy: remain in MULTI, stalls held, cnt stays 0.
- DRAIN:
  - Stall all three stages until mem_valid=0, wb_valid=0 and mem_busy=0.
  - In that cycle: fence_done=1, id_flush=1, stalls released; go to RUN. The instruction after the fence is refetched by the core.
- ex_bubble and id_stall are never asserted together.
- reset falling mid-MULTI or mid-DRAIN aborts immediately to RUN; no completion pulse is generated.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - perf_stall increments every cycle in which if_stall=1.
  - perf_flush increments every cycle in which id_flush=1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports are tied to constant 0 and no counter flops are built.

Test Plan:
- Load-use: EX lw x5 (ex_mem_ena=1, ex_mem_wr=0, ex_w_addr=5, ex_w_ena=1); ID add reads rs1=5 -> if_stall=1, ex_bubble=1 for exactly 1 cycle. Same case with ex_w_addr=0 -> no stall.
- Redirect beats load-use: ex_redirect=1 with lu true the same cycle -> pc_redirect=1, id_flush=1, ex_bubble=1, if_stall=0.
- Multi-cycle with MULTI_LAT=4: ex_multi asserted at cycle 0 -> ex_stall=1 in cycles 0..2, 0 in cycle 3, state back to RUN after cycle 3.
- Multi-cycle plus back-pressure: mem_busy=1 during cycles 2..5 of the above -> stalls held through cycle 5, released in cycle 6, EX advances once only.
- Fence: ex_fence=1 with mem_valid=1, wb_valid=1; clear mem_valid at cycle 2 and wb_valid at cycle 3 -> stalls held in cycles 0..2, fence_done=1 and id_flush=1 in cycle 3.
- Reset: drive reset=0 asynchronously mid-MULTI -> all outputs 0 immediately, state RUN. With PIPE_CTRL_PERF_EN defined, after the first load-use case perf_stall=1 and perf_flush=0.
